// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared parameters, counter sizing and FSM encoding for the carry-save resolver
// Optional feature macro used by the resolver: CSA_RESOLVE_OVF_EN
package csa_pkg;

    localparam int CSA_WIDTH  = 24;
    localparam int CSA_CHUNK  = 8;
    localparam int CSA_NCHUNK = CSA_WIDTH / CSA_CHUNK;

    // Chunk index counter width; never below one bit so a single-chunk build still has a counter.
    function automatic int csa_cnt_width(input int nchunk);
        int w;
        w = $clog2(nchunk);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } csa_res_state_t;

endpackage

// File: rtl/csa_chunk_adder.sv
// rtl/csa_chunk_adder.sv - CHUNK-bit combinational adder with carry in and carry out
// Ports: a, b  - CHUNK-bit operands
//        cin   - carry into bit 0
//        sum   - CHUNK-bit sum
//        cout  - carry out of the top bit
module csa_chunk_adder
    import csa_pkg::*;
#(
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/csa_resolve_seq.sv
// rtl/csa_resolve_seq.sv - sequential carry-save resolver, R = S + (C << 1) one chunk per cycle
// Optional feature: define CSA_RESOLVE_OVF_EN to add the ovf output.
// Ports: clk, rst           - clock, synchronous active-high reset
//        in_valid/in_ready  - input handshake for the s_in/c_in pair
//        s_in, c_in         - carry-save sum and carry vectors (c_in bit i weighs 2^(i+1))
//        out_valid/out_ready- output handshake, result held until accepted
//        result             - (S + (C << 1)) mod 2^WIDTH
//        ovf                - (CSA_RESOLVE_OVF_EN only) true sum did not fit in WIDTH bits
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] c_in,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_RESOLVE_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = csa_cnt_width(NCHUNK);
    localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolve_seq: WIDTH must be a multiple of CHUNK");
    end

    csa_res_state_t   state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] csh_q, csh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

`ifdef CSA_RESOLVE_OVF_EN
    logic msb_c_q, msb_c_d;
    logic ovf_q, ovf_d;
`else
    // The carry vector's top bit only matters for overflow reporting.
    logic unused_msb_c;
    assign unused_msb_c = c_in[WIDTH-1];
`endif

    // One adder slice is reused for every chunk; the counter picks which slice of S/Csh feeds it.
    assign chunk_a = s_q[int'(k_q)*CHUNK +: CHUNK];
    assign chunk_b = csh_q[int'(k_q)*CHUNK +: CHUNK];

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        csh_d    = csh_q;
        carry_d  = carry_q;
        k_d      = k_q;
        result_d = result_q;
`ifdef CSA_RESOLVE_OVF_EN
        msb_c_d  = msb_c_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = s_in;
                    csh_d   = {c_in[WIDTH-2:0], 1'b0};
                    carry_d = 1'b0;
                    k_d     = '0;
`ifdef CSA_RESOLVE_OVF_EN
                    msb_c_d = c_in[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d[int'(k_q)*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = HOLD;
`ifdef CSA_RESOLVE_OVF_EN
                    // Bit WIDTH of the true sum comes from either the final ripple or C's dropped msb.
                    ovf_d   = chunk_cout | msb_c_q;
`endif
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            csh_q    <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
`ifdef CSA_RESOLVE_OVF_EN
            msb_c_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            csh_q    <= csh_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            result_q <= result_d;
`ifdef CSA_RESOLVE_OVF_EN
            msb_c_q  <= msb_c_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
`ifdef CSA_RESOLVE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
